// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: owner tags, lock states and
// the byte-offset width that separates byte addresses from word addresses.
package dmem_arbiter_pkg;

  typedef enum logic {
    OWNER_CORE  = 1'b0,
    OWNER_DEBUG = 1'b1
  } owner_e;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int BYTE_OFS_W = 2;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin grant generator. On a tie, the port that was not
// granted most recently wins; the last-owner register moves only on a grant.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_core,
  input  logic req_dbg,
  output logic gnt_core,
  output logic gnt_dbg
);

  owner_e last_owner;

  always_comb begin
    gnt_core = 1'b0;
    gnt_dbg  = 1'b0;
    if (req_core && req_dbg) begin
      if (last_owner == OWNER_DEBUG) gnt_core = 1'b1;
      else                           gnt_dbg  = 1'b1;
    end else begin
      gnt_core = req_core;
      gnt_dbg  = req_dbg;
    end
  end

  // Reset to DEBUG so the core wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        last_owner <= OWNER_DEBUG;
    else if (gnt_core) last_owner <= OWNER_CORE;
    else if (gnt_dbg)  last_owner <= OWNER_DEBUG;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core load/store path and a
// debug/loader port, with an exclusive debug-lock mode and read-data routing.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [31:0]   core_addr,
  input  logic [31:0]   core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  output logic [31:0]   core_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [31:0]   dbg_addr,
  input  logic [31:0]   dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          locked,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [AW-1:0] WORD_MASK = AW'(DEPTH - 1);

  state_e  state_q, state_d;
  logic    core_allow;
  logic    rd_pend_q;
  owner_e  rd_owner_q;
  logic [AW-1:0] core_word, dbg_word;
  logic    unused_addr_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_NORMAL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_NORMAL;
    if (dbg_lock) state_d = ST_LOCKED;
  end

  // Lock acts on registered state, so the cycle dbg_lock rises still arbitrates normally.
  always_comb begin
    locked     = 1'b0;
    core_allow = 1'b1;
    if (state_q == ST_LOCKED) begin
      locked     = 1'b1;
      core_allow = 1'b0;
    end
  end

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_core (core_req & core_allow),
    .req_dbg  (dbg_req),
    .gnt_core (core_gnt),
    .gnt_dbg  (dbg_gnt)
  );

  assign core_stall = core_req & ~core_gnt;

  assign core_word = core_addr[AW+BYTE_OFS_W-1:BYTE_OFS_W] & WORD_MASK;
  assign dbg_word  = dbg_addr[AW+BYTE_OFS_W-1:BYTE_OFS_W] & WORD_MASK;
  assign unused_addr_bits = ^{core_addr[31:AW+BYTE_OFS_W], core_addr[BYTE_OFS_W-1:0],
                              dbg_addr[31:AW+BYTE_OFS_W], dbg_addr[BYTE_OFS_W-1:0]};

  always_comb begin
    mem_en    = core_gnt | dbg_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_word;
      mem_wdata = dbg_wdata;
    end else if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_word;
      mem_wdata = core_wdata;
    end
  end

  // Tag each granted read so the next cycle's memory data reaches its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_CORE;
    end else begin
      rd_pend_q <= mem_en & ~mem_we;
      if (dbg_gnt) rd_owner_q <= OWNER_DEBUG;
      else         rd_owner_q <= OWNER_CORE;
    end
  end

  assign core_rvalid = rd_pend_q && (rd_owner_q == OWNER_CORE);
  assign dbg_rvalid  = rd_pend_q && (rd_owner_q == OWNER_DEBUG);
  assign core_rdata  = core_rvalid ? mem_rdata : 32'h0;
  assign dbg_rdata   = dbg_rvalid  ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural memory behind the arbiter and
// a scoreboard of expected read returns built from a shadow copy of memory.
module tb_dmem_arbiter;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk;
  logic          rst_n;
  logic          core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0]   core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic          core_gnt, core_stall, core_rvalid, dbg_gnt, dbg_rvalid, locked;
  logic [31:0]   core_rdata, dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] mem_model [DEPTH];
  logic [31:0] shadow    [DEPTH];

  typedef struct {
    logic        to_dbg;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .locked(locked), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: read data appears the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkReturn(input string name);
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({name, ":core_rvalid"}, 32'(core_rvalid), 32'(!e.to_dbg));
      checkOutput({name, ":dbg_rvalid"},  32'(dbg_rvalid),  32'(e.to_dbg));
      checkOutput({name, ":core_rdata"},  core_rdata, e.to_dbg ? 32'h0 : e.data);
      checkOutput({name, ":dbg_rdata"},   dbg_rdata,  e.to_dbg ? e.data : 32'h0);
    end else begin
      checkOutput({name, ":core_rvalid_idle"}, 32'(core_rvalid), 32'h0);
      checkOutput({name, ":dbg_rvalid_idle"},  32'(dbg_rvalid),  32'h0);
    end
  endtask

  // One clock cycle: drive requests, then at the falling edge check grants,
  // memory drive and any read return due from the previous cycle.
  task automatic applyStimulus(
    input string name,
    input logic c_req, input logic c_we, input logic [31:0] c_addr, input logic [31:0] c_wdata,
    input logic d_req, input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wdata,
    input logic lock,
    input logic exp_cg, input logic exp_dg, input logic exp_locked);
    logic [AW-1:0] w;
    core_req = c_req; core_we = c_we; core_addr = c_addr; core_wdata = c_wdata;
    dbg_req  = d_req; dbg_we  = d_we; dbg_addr  = d_addr; dbg_wdata  = d_wdata;
    dbg_lock = lock;
    @(negedge clk);
    checkReturn(name);
    checkOutput({name, ":core_gnt"},   32'(core_gnt),   32'(exp_cg));
    checkOutput({name, ":dbg_gnt"},    32'(dbg_gnt),    32'(exp_dg));
    checkOutput({name, ":core_stall"}, 32'(core_stall), 32'(c_req & ~exp_cg));
    checkOutput({name, ":locked"},     32'(locked),     32'(exp_locked));
    checkOutput({name, ":mem_en"},     32'(mem_en),     32'(exp_cg | exp_dg));
    if (exp_cg || exp_dg) begin
      w = exp_dg ? d_addr[AW+1:2] : c_addr[AW+1:2];
      checkOutput({name, ":mem_addr"}, 32'(mem_addr), 32'(w));
      checkOutput({name, ":mem_we"},   32'(mem_we),   32'(exp_dg ? d_we : c_we));
      if (exp_dg ? d_we : c_we) begin
        checkOutput({name, ":mem_wdata"}, mem_wdata, exp_dg ? d_wdata : c_wdata);
        shadow[w] = exp_dg ? d_wdata : c_wdata;
      end else begin
        sb.push_back('{to_dbg: exp_dg, data: shadow[w]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset(input string name);
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dbg_req  = 1'b0; dbg_we  = 1'b0; dbg_addr  = '0; dbg_wdata  = '0;
    dbg_lock = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    @(negedge clk);
    checkOutput({name, ":core_gnt"},    32'(core_gnt),    32'h0);
    checkOutput({name, ":dbg_gnt"},     32'(dbg_gnt),     32'h0);
    checkOutput({name, ":core_stall"},  32'(core_stall),  32'h0);
    checkOutput({name, ":core_rvalid"}, 32'(core_rvalid), 32'h0);
    checkOutput({name, ":dbg_rvalid"},  32'(dbg_rvalid),  32'h0);
    checkOutput({name, ":core_rdata"},  core_rdata,       32'h0);
    checkOutput({name, ":dbg_rdata"},   dbg_rdata,        32'h0);
    checkOutput({name, ":locked"},      32'(locked),      32'h0);
    checkOutput({name, ":mem_en"},      32'(mem_en),      32'h0);
    checkOutput({name, ":mem_we"},      32'(mem_we),      32'h0);
    checkOutput({name, ":mem_addr"},    32'(mem_addr),    32'h0);
    checkOutput({name, ":mem_wdata"},   mem_wdata,        32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_model[i] = 32'h0;
      shadow[i]    = 32'h0;
    end
    mem_model[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
    mem_model[5] = 32'hCAFEF00D; shadow[5] = 32'hCAFEF00D;
    mem_rdata = 32'h0;

    #1;
    applyReset("reset");

    // Tie after reset: core first, then alternating; both hold their loads.
    applyStimulus("tie0", 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0, 1, 0, 0);
    applyStimulus("tie1", 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0, 0, 1, 0);
    applyStimulus("tie2", 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0, 1, 0, 0);
    applyStimulus("tie3", 1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0, 0, 1, 0);

    // Core-only load of word 4.
    applyStimulus("core_ld", 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("core_ld_ret", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Core store then debug load of the same word on the next cycle.
    applyStimulus("wr_core", 1, 1, 32'h20, 32'hA5, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("rd_dbg",  0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 0);

    // Debug store wraps modulo DEPTH words; read back through the core.
    applyStimulus("wrap_wr", 0, 0, 0, 0, 1, 1, 32'h400, 32'h1234, 0, 0, 1, 0);
    applyStimulus("wrap_rd", 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Lock rises with a core load granted; the read still returns while locked.
    applyStimulus("lock_rise", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyStimulus("lock_hold", 1, 1, 32'h30, 32'h77, 0, 0, 0, 0, 1, 0, 0, 1);
    applyStimulus("lock_dbg",  1, 1, 32'h30, 32'h77, 1, 0, 32'h30, 0, 1, 0, 1, 1);
    applyStimulus("lock_fall", 1, 1, 32'h30, 32'h77, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus("unlocked",  1, 1, 32'h30, 32'h77, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("post_lock", 0, 0, 0, 0, 1, 0, 32'h30, 0, 0, 0, 1, 0);

    // Back-to-back alternating owners, read return overlapping a new grant.
    applyStimulus("b2b0", 1, 0, 32'h14, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus("b2b1", 0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 0);
    applyStimulus("b2b2", 1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 1, 0, 0);

    // Reset in the cycle after a granted core load while lock is rising.
    applyStimulus("pre_rst", 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    applyReset("mid_reset");
    applyStimulus("tie_after_rst", 1, 0, 32'h14, 0, 1, 0, 32'h10, 0, 0, 1, 0, 0);
    applyStimulus("tie_after_rst2", 0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0, 1, 0);
    applyStimulus("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
